// File: rtl/fpu_issue_scheduler.sv
// Round-robin issue of client FP operations onto one shared FPU, with result routing back to the client.
// Optional: define FPU_SCHED_PRIORITY_EN to give client 0 fixed priority over the round-robin clients.
module fpu_issue_scheduler #(
    parameter int REQUESTERS   = 4,
    parameter int PIPE_LATENCY = 5,
    parameter int ITER_LATENCY = 26
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REQUESTERS-1:0]     req_valid,
    output logic [REQUESTERS-1:0]     req_ready,
    input  logic [3*REQUESTERS-1:0]   req_calc,
    input  logic [32*REQUESTERS-1:0]  req_a,
    input  logic [32*REQUESTERS-1:0]  req_b,
    output logic                      fpu_start,
    output logic [2:0]                fpu_calc,
    output logic [31:0]               fpu_a,
    output logic [31:0]               fpu_b,
    input  logic [31:0]               fpu_result,
    output logic [REQUESTERS-1:0]     rsp_valid,
    output logic [31:0]               rsp_result,
    output logic [REQUESTERS-1:0]     err_valid
);
    localparam int ID_W  = $clog2(REQUESTERS);
    localparam int CNT_W = $clog2(ITER_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(ITER_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PIPE_HIT = CNT_W'(PIPE_LATENCY + 1);
    localparam logic [ID_W-1:0]  LAST_ID      = ID_W'(REQUESTERS - 1);

    logic                    fpu_start_q, fpu_start_d;
    logic [2:0]              fpu_calc_q, fpu_calc_d;
    logic [31:0]             fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic [REQUESTERS-1:0]   rsp_valid_q, rsp_valid_d;
    logic [REQUESTERS-1:0]   err_valid_q, err_valid_d;
    logic [ID_W-1:0]         last_grant_q, last_grant_d;
    logic [PIPE_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [ID_W-1:0]         pipe_id_q [PIPE_LATENCY];
    logic [ID_W-1:0]         pipe_id_d [PIPE_LATENCY];
    logic [CNT_W-1:0]        iter_count_q, iter_count_d;
    logic [ID_W-1:0]         iter_id_q, iter_id_d;

    logic [REQUESTERS-1:0]   elig, elig_rr, grant;
    logic [ID_W-1:0]         grant_id, hi_id, lo_id;
    logic                    grant_any, hi_found, lo_found;
    logic                    grant_legal, grant_iter;
    logic [2:0]              grant_calc;
    logic [31:0]             grant_a, grant_b;
    logic                    pipe_done, iter_done;

    // iter_count holds the cycles left until the iterative result strobe, so a pipelined op
    // accepted at PIPE_LATENCY+1 would land on the same cycle and an iterative op may
    // be accepted once only the final cycle remains.
    always_comb begin
        elig = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (req_calc[3*i +: 3] <= 3'd2) begin
                elig[i] = req_valid[i] && (iter_count_q != CNT_PIPE_HIT);
            end else if (req_calc[3*i +: 3] <= 3'd4) begin
                elig[i] = req_valid[i] && (iter_count_q <= CNT_ONE);
            end else begin
                elig[i] = req_valid[i];
            end
        end
    end

    always_comb begin
        elig_rr  = elig;
`ifdef FPU_SCHED_PRIORITY_EN
        elig_rr[0] = 1'b0;
`endif
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (elig_rr[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
            end
            if (elig_rr[i] && !hi_found && (ID_W'(i) > last_grant_q)) begin
                hi_found = 1'b1;
                hi_id    = ID_W'(i);
            end
        end
        grant_any = hi_found || lo_found;
        grant_id  = hi_found ? hi_id : lo_id;
`ifdef FPU_SCHED_PRIORITY_EN
        if (elig[0]) begin
            grant_any = 1'b1;
            grant_id  = '0;
        end
`endif
        if (reset) begin
            grant_any = 1'b0;
        end
        grant      = '0;
        grant_calc = '0;
        grant_a    = '0;
        grant_b    = '0;
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant[i]) begin
                grant_calc = req_calc[3*i +: 3];
                grant_a    = req_a[32*i +: 32];
                grant_b    = req_b[32*i +: 32];
            end
        end
        grant_legal = grant_any && (grant_calc <= 3'd4);
        grant_iter  = grant_legal && (grant_calc >= 3'd3);
    end

    always_comb begin
        fpu_start_d = grant_legal;
        fpu_calc_d  = fpu_calc_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        if (grant_legal) begin
            fpu_calc_d = grant_calc;
            fpu_a_d    = grant_a;
            fpu_b_d    = grant_b;
        end
        err_valid_d = (grant_any && !grant_legal) ? grant : '0;

        last_grant_d = last_grant_q;
`ifdef FPU_SCHED_PRIORITY_EN
        if (grant_any && (grant_id != '0)) begin
            last_grant_d = grant_id;
        end
`else
        if (grant_any) begin
            last_grant_d = grant_id;
        end
`endif

        pipe_vld_d   = {pipe_vld_q[PIPE_LATENCY-2:0], grant_legal && !grant_iter};
        pipe_id_d[0] = grant_id;
        for (int k = 1; k < PIPE_LATENCY; k++) begin
            pipe_id_d[k] = pipe_id_q[k-1];
        end

        iter_count_d = iter_count_q;
        iter_id_d    = iter_id_q;
        if (iter_count_q != '0) begin
            iter_count_d = iter_count_q - CNT_ONE;
        end
        if (grant_iter) begin
            iter_count_d = CNT_LOAD;
            iter_id_d    = grant_id;
        end

        pipe_done   = pipe_vld_q[PIPE_LATENCY-1];
        iter_done   = (iter_count_q == CNT_ONE);
        rsp_valid_d = '0;
        if (pipe_done) begin
            rsp_valid_d[pipe_id_q[PIPE_LATENCY-1]] = 1'b1;
        end
        if (iter_done) begin
            rsp_valid_d[iter_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpu_start_q  <= 1'b0;
            fpu_calc_q   <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            rsp_valid_q  <= '0;
            err_valid_q  <= '0;
            last_grant_q <= LAST_ID;
            pipe_vld_q   <= '0;
            for (int k = 0; k < PIPE_LATENCY; k++) begin
                pipe_id_q[k] <= '0;
            end
            iter_count_q <= '0;
            iter_id_q    <= '0;
        end else begin
            assert (!(pipe_done && iter_done));
            fpu_start_q  <= fpu_start_d;
            fpu_calc_q   <= fpu_calc_d;
            fpu_a_q      <= fpu_a_d;
            fpu_b_q      <= fpu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            err_valid_q  <= err_valid_d;
            last_grant_q <= last_grant_d;
            pipe_vld_q   <= pipe_vld_d;
            for (int k = 0; k < PIPE_LATENCY; k++) begin
                pipe_id_q[k] <= pipe_id_d[k];
            end
            iter_count_q <= iter_count_d;
            iter_id_q    <= iter_id_d;
        end
    end

    assign req_ready  = grant;
    assign fpu_start  = fpu_start_q;
    assign fpu_calc   = fpu_calc_q;
    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = fpu_result;
    assign err_valid  = err_valid_q;

endmodule
